uart_rx_core: RTL and testbench

UART receiver stage that sits directly upstream of the LED/byte consumer in the board top level. It converts the asynchronous serial line rx_i into parallel bytes, 8N1 format, LSB first. Each good byte is presented on a held output and flagged with a one-cycle strobe. Framing errors and line breaks are flagged separately and never update the byte output.

---
 rtl/uart_rx_core.sv | 145 ++++++++++++++
 tb/tb_uart_rx_core.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver, LSB first, mid-bit sampling.
// A two-flop synchronizer feeds a small FSM that uses a bit timer.
// Good bytes are held on rx_byte_o and flagged by a one-cycle strobe.
// A low stop bit raises a one-cycle framing-error strobe instead, and
// the FSM then waits for the line to return high.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | line idle, waiting for rx_s low (start edge)
// S_START | timing half a bit to re-check the start bit (glitch filter)
// S_DATA  | sampling 8 data bits, one every CLKS_PER_BIT cycles
// S_STOP  | sampling the stop bit at its midpoint
// S_BREAK | stop bit was low; wait for line high before re-arming

module uart_rx_core #(
   parameter  int CLKS_PER_BIT = 434,
   localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_i,
   output logic [7:0] rx_byte_o,
   output logic       rx_valid_o,
   output logic       frame_err_o,
   output logic       busy_o
);

   generate
      if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_param
         $error("uart_rx_core: CLKS_PER_BIT must be within 4..65535");
      end
   endgenerate

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_BREAK = 3'd4;

   // Sample points: half a bit after the start edge, then every full bit.
   localparam logic [CNT_W-1:0] LP_HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] LP_FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic [2:0]       r_state;
   logic [CNT_W-1:0] r_timer;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;
   logic [7:0]       r_rx_byte;
   logic             r_rx_valid;
   logic             r_frame_err;
   logic             r_busy;

   logic             w_rx_s;
   logic             w_tick;
   logic [2:0]       w_state_nxt;

   assign w_rx_s = r_sync2;

   assign w_tick = ((r_state == S_START) && (r_timer == LP_HALF_M1)) ||
                   (((r_state == S_DATA) || (r_state == S_STOP)) &&
                    (r_timer == LP_FULL_M1));

   // Synchronize rx_i; flops reset high so reset never looks like a start edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rx_i;
         r_sync2 <= r_sync1;
      end
   end

   // Next-state decode; all decisions are taken on sample ticks or rx_s level.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (!w_rx_s) w_state_nxt = S_START;
         S_START: if (w_tick)  w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
         S_DATA:  if (w_tick && (r_bit_idx == 3'd7)) w_state_nxt = S_STOP;
         S_STOP:  if (w_tick)  w_state_nxt = w_rx_s ? S_IDLE : S_BREAK;
         S_BREAK: if (w_rx_s)  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Bit timer: held at zero while idle, wraps to zero at every sample point.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_timer <= '0;
      end else if (w_tick || (r_state == S_IDLE) || (r_state == S_BREAK)) begin
         r_timer <= '0;
      end else begin
         r_timer <= r_timer + CNT_W'(1);
      end
   end

   // Bit index and LSB-first shift register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_bit_idx <= 3'd0;
         r_shift   <= 8'h00;
      end else if (r_state == S_START) begin
         r_bit_idx <= 3'd0;
      end else if ((r_state == S_DATA) && w_tick) begin
         r_bit_idx <= r_bit_idx + 3'd1;
         r_shift   <= {w_rx_s, r_shift[7:1]};
      end
   end

   // Registered outputs: strobes at the stop-bit sample, byte only on good stop.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rx_byte   <= 8'h00;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_rx_valid  <= (r_state == S_STOP) && w_tick && w_rx_s;
         r_frame_err <= (r_state == S_STOP) && w_tick && !w_rx_s;
         if ((r_state == S_STOP) && w_tick && w_rx_s) begin
            r_rx_byte <= r_shift;
         end
         // busy tracks "not idle", so it stays high through S_BREAK.
         r_busy <= (w_state_nxt != S_IDLE);
      end
   end

   assign rx_byte_o   = r_rx_byte;
   assign rx_valid_o  = r_rx_valid;
   assign frame_err_o = r_frame_err;
   assign busy_o      = r_busy;

endmodule

// File: tb/tb_uart_rx_core.sv
// Testbench for uart_rx_core: a CLKS_PER_BIT=8 instance for functional and
// timing checks, and a CLKS_PER_BIT=434 instance for a skewed-baud frame.
`timescale 1ns/1ps

module tb_uart_rx_core;

   localparam int C8  = 8;
   localparam int H8  = C8 / 2;
   // Line falls at a negedge with cyc=f; sync makes rx_s low after edge f+2
   // (T0), strobe is visible after edge T0+H+9C+1.
   localparam int LAT8 = 2 + H8 + 9 * C8 + 1;   // 79

   logic clk;
   logic rst;
   logic rx8;
   logic rx434;
   logic [7:0] byte8, byte434;
   logic valid8, valid434, err8, err434, busy8, busy434;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int excl_viol = 0;

   int   vq_cyc[$];
   int   vq_byte[$];
   int   eq_cyc[$];
   int   v434_n = 0;
   int   e434_n = 0;
   bit   busy_hist [0:65535];

   typedef struct {
      logic [7:0] data;
      bit         stop;
      int         exp_valid;
      int         exp_err;
      logic [7:0] exp_byte;
   } vec_t;

   vec_t vecs[6];

   uart_rx_core #(.CLKS_PER_BIT(8)) dut8 (
      .clk_i(clk), .rst_i(rst), .rx_i(rx8),
      .rx_byte_o(byte8), .rx_valid_o(valid8),
      .frame_err_o(err8), .busy_o(busy8)
   );

   uart_rx_core #(.CLKS_PER_BIT(434)) dut434 (
      .clk_i(clk), .rst_i(rst), .rx_i(rx434),
      .rx_byte_o(byte434), .rx_valid_o(valid434),
      .frame_err_o(err434), .busy_o(busy434)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      busy_hist[16'(cyc)] = busy8;
      if (valid8) begin
         vq_cyc.push_back(cyc);
         vq_byte.push_back(int'(byte8));
      end
      if (err8) eq_cyc.push_back(cyc);
      if (valid8 && err8) excl_viol++;
      if (valid434) v434_n++;
      if (err434) e434_n++;
      if (valid434 && err434) excl_viol++;
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_line(input bit wide, input logic v);
      if (wide) rx434 = v;
      else      rx8   = v;
   endtask

   // Drive one 8N1 frame starting at the current negedge; returns the
   // cycle count at which the start bit was put on the line.
   task automatic send_frame(input bit wide, input logic [7:0] d,
                             input logic stop, input int len, output int f);
      set_line(wide, 1'b0);
      f = cyc;
      repeat (len) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         set_line(wide, d[i]);
         repeat (len) @(negedge clk);
      end
      set_line(wide, stop);
      repeat (len) @(negedge clk);
      set_line(wide, 1'b1);
   endtask

   task automatic clear_events();
      vq_cyc.delete();
      vq_byte.delete();
      eq_cyc.delete();
   endtask

   initial begin
      int f, f2, lat, nlow;
      rst   = 1'b1;
      rx8   = 1'b1;
      rx434 = 1'b1;

      vecs[0] = '{8'h55, 1'b1, 1, 0, 8'h55};
      vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
      vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
      vecs[3] = '{8'h81, 1'b0, 0, 1, 8'hFF};
      vecs[4] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
      vecs[5] = '{8'hA5, 1'b1, 1, 0, 8'hA5};

      repeat (3) @(negedge clk);
      check("reset byte",  int'(byte8),  0);
      check("reset valid", int'(valid8), 0);
      check("reset err",   int'(err8),   0);
      check("reset busy",  int'(busy8),  0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Table-driven single frames with a quiet gap after each.
      for (int k = 0; k < 6; k++) begin
         clear_events();
         send_frame(1'b0, vecs[k].data, vecs[k].stop, C8, f);
         repeat (20) @(negedge clk);
         check($sformatf("vec%0d valid count", k), vq_cyc.size(), vecs[k].exp_valid);
         check($sformatf("vec%0d err count", k), eq_cyc.size(), vecs[k].exp_err);
         check($sformatf("vec%0d byte", k), int'(byte8), int'(vecs[k].exp_byte));
         check($sformatf("vec%0d busy idle", k), int'(busy8), 0);
         if (vecs[k].exp_valid != 0)
            lat = (vq_cyc.size() > 0) ? vq_cyc[0] - f : -1;
         else
            lat = (eq_cyc.size() > 0) ? eq_cyc[0] - f : -1;
         check($sformatf("vec%0d strobe latency", k), lat, LAT8);
      end

      // Back-to-back frames: second start bit follows the stop bit directly.
      clear_events();
      send_frame(1'b0, 8'hA3, 1'b1, C8, f);
      send_frame(1'b0, 8'h0F, 1'b1, C8, f2);
      repeat (20) @(negedge clk);
      check("b2b valid count", vq_cyc.size(), 2);
      check("b2b byte0", (vq_byte.size() > 0) ? vq_byte[0] : -1, 8'hA3);
      check("b2b byte1", (vq_byte.size() > 1) ? vq_byte[1] : -1, 8'h0F);
      check("b2b spacing", (vq_cyc.size() > 1) ? vq_cyc[1] - vq_cyc[0] : -1, 10 * C8);
      nlow = 0;
      if (vq_cyc.size() > 1)
         for (int c = vq_cyc[0]; c < vq_cyc[1]; c++)
            if (!busy_hist[16'(c)]) nlow++;
      // busy drops at mid-stop and rises the cycle after the next T0: C-H cycles.
      check("b2b busy gap", nlow, C8 - H8);
      check("b2b err count", eq_cyc.size(), 0);

      // Two-cycle low glitch on the idle line.
      clear_events();
      rx8 = 1'b0;
      f = cyc;
      repeat (2) @(negedge clk);
      rx8 = 1'b1;
      repeat (30) @(negedge clk);
      check("glitch busy at T0+4", int'(busy_hist[16'(f + 2 + H8)]), 1);
      check("glitch busy at T0+5", int'(busy_hist[16'(f + 2 + H8 + 1)]), 0);
      check("glitch valid count", vq_cyc.size(), 0);
      check("glitch err count", eq_cyc.size(), 0);
      check("glitch byte kept", int'(byte8), 8'h0F);

      // Stop bit low, then line held low (break) for 200 cycles.
      clear_events();
      send_frame(1'b0, 8'h81, 1'b0, C8, f);
      rx8 = 1'b0;
      repeat (200) @(negedge clk);
      check("break err count", eq_cyc.size(), 1);
      check("break err latency", (eq_cyc.size() > 0) ? eq_cyc[0] - f : -1, LAT8);
      check("break valid count", vq_cyc.size(), 0);
      check("break byte kept", int'(byte8), 8'h0F);
      rx8 = 1'b1;
      repeat (10) @(negedge clk);
      check("break exit busy", int'(busy8), 0);
      send_frame(1'b0, 8'h3C, 1'b1, C8, f);
      repeat (20) @(negedge clk);
      check("after break byte", int'(byte8), 8'h3C);
      check("after break valid count", vq_cyc.size(), 1);
      check("after break err count", eq_cyc.size(), 1);

      // Asynchronous reset during data bit 4; the frame must be abandoned.
      clear_events();
      fork
         send_frame(1'b0, 8'h5A, 1'b1, C8, f);
         begin
            repeat (5 * C8 + 4) @(negedge clk);
            check("pre-reset busy", int'(busy8), 1);
            #2 rst = 1'b1;
            #1;
            check("async rst byte",  int'(byte8),  0);
            check("async rst valid", int'(valid8), 0);
            check("async rst err",   int'(err8),   0);
            check("async rst busy",  int'(busy8),  0);
         end
      join
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("reset frame strobes", vq_cyc.size() + eq_cyc.size(), 0);
      send_frame(1'b0, 8'hC6, 1'b1, C8, f);
      repeat (20) @(negedge clk);
      check("post-reset byte", int'(byte8), 8'hC6);
      check("post-reset valid count", vq_cyc.size(), 1);

      // 115200 baud at 50 MHz, sender bit period 3% long (447 cycles).
      send_frame(1'b1, 8'hE7, 1'b1, 447, f);
      repeat (300) @(negedge clk);
      check("skew byte", int'(byte434), 8'hE7);
      check("skew valid count", v434_n, 1);
      check("skew err count", e434_n, 0);

      check("strobe exclusivity", excl_viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
